// File: rtl/ysyx_22050019_axi_pkg.sv
// Shared AXI-lite types and constants for the core's memory fabric.
package ysyx_22050019_axi_pkg;

    localparam int DEF_ADDR_W = 64;
    localparam int DEF_DATA_W = 64;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_ADDR,
        ST_WR_RESP
    } arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_IFU_RD,
        GNT_LSU_RD,
        GNT_LSU_WR
    } grant_e;

endpackage

// File: rtl/axi_lite_rr_grant.sv
// Alternating-priority grant between IFU reads and LSU reads/writes.
module axi_lite_rr_grant
    import ysyx_22050019_axi_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   en,
    input  logic   ifu_rd,
    input  logic   lsu_rd,
    input  logic   lsu_aw,
    input  logic   lsu_w,
    output grant_e grant,
    output logic   last_lsu
);

    // The IFU jumps the queue only when the LSU won last time.
    always_comb begin
        grant = GNT_NONE;
        if (en) begin
            if (last_lsu && ifu_rd) begin
                grant = GNT_IFU_RD;
            end else if (lsu_aw && lsu_w) begin
                grant = GNT_LSU_WR;
            end else if (lsu_rd) begin
                grant = GNT_LSU_RD;
            end else if (ifu_rd) begin
                grant = GNT_IFU_RD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_lsu <= 1'b0;
        end else if (grant == GNT_IFU_RD) begin
            last_lsu <= 1'b0;
        end else if (grant != GNT_NONE) begin
            last_lsu <= 1'b1;
        end
    end

endmodule

// File: rtl/axi_lite_sram_arbiter.sv
// Two-master AXI-lite arbiter (IFU, LSU) in front of the single SRAM slave.
module axi_lite_sram_arbiter
    import ysyx_22050019_axi_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    input  logic [ADDR_W-1:0] ifu_araddr,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,

    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,

    input  logic              lsu_awvalid,
    output logic              lsu_awready,
    input  logic [ADDR_W-1:0] lsu_awaddr,
    input  logic              lsu_wvalid,
    output logic              lsu_wready,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [STRB_W-1:0] lsu_wstrb,
    output logic              lsu_bvalid,
    input  logic              lsu_bready,
    output logic [1:0]        lsu_bresp,

    output logic              s_arvalid,
    input  logic              s_arready,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_rvalid,
    output logic              s_rready,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,

    output logic              s_awvalid,
    input  logic              s_awready,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_wvalid,
    input  logic              s_wready,
    output logic [DATA_W-1:0] s_wdata,
    output logic [STRB_W-1:0] s_wstrb,
    input  logic              s_bvalid,
    output logic              s_bready,
    input  logic [1:0]        s_bresp
);

    arb_state_e        state_q, state_d;
    grant_e            grant;
    logic              last_lsu;
    logic              sel_lsu;
    logic              aw_done, aw_done_d;
    logic              w_done, w_done_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] wstrb_q;

    logic rd_phase, wr_phase, b_phase;
    logic aw_ok, w_ok;

    axi_lite_rr_grant u_grant (
        .clk      (clk),
        .rst      (rst),
        .en       (state_q == ST_IDLE && !rst),
        .ifu_rd   (ifu_arvalid),
        .lsu_rd   (lsu_arvalid),
        .lsu_aw   (lsu_awvalid),
        .lsu_w    (lsu_wvalid),
        .grant    (grant),
        .last_lsu (last_lsu)
    );

    assign rd_phase = (state_q == ST_RD_DATA);
    assign wr_phase = (state_q == ST_WR_ADDR);
    assign b_phase  = (state_q == ST_WR_RESP);

    assign ifu_arready = (grant == GNT_IFU_RD);
    assign lsu_arready = (grant == GNT_LSU_RD);
    assign lsu_awready = (grant == GNT_LSU_WR);
    assign lsu_wready  = (grant == GNT_LSU_WR);

    // Slave request channels are driven from registers only.
    assign s_arvalid = (state_q == ST_RD_ADDR);
    assign s_awvalid = wr_phase && !aw_done;
    assign s_wvalid  = wr_phase && !w_done;
    assign s_araddr  = addr_q;
    assign s_awaddr  = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;

    assign aw_ok = aw_done || (s_awvalid && s_awready);
    assign w_ok  = w_done  || (s_wvalid  && s_wready);

    assign ifu_rvalid = rd_phase && !sel_lsu && s_rvalid;
    assign ifu_rdata  = (rd_phase && !sel_lsu) ? s_rdata : '0;
    assign ifu_rresp  = (rd_phase && !sel_lsu) ? s_rresp : OKAY;
    assign lsu_rvalid = rd_phase && sel_lsu && s_rvalid;
    assign lsu_rdata  = (rd_phase && sel_lsu) ? s_rdata : '0;
    assign lsu_rresp  = (rd_phase && sel_lsu) ? s_rresp : OKAY;
    assign s_rready   = rd_phase && (sel_lsu ? lsu_rready : ifu_rready);

    assign lsu_bvalid = b_phase && s_bvalid;
    assign lsu_bresp  = b_phase ? s_bresp : OKAY;
    assign s_bready   = b_phase && lsu_bready;

    always_comb begin
        state_d   = state_q;
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                unique case (grant)
                    GNT_IFU_RD, GNT_LSU_RD: state_d = ST_RD_ADDR;
                    GNT_LSU_WR:             state_d = ST_WR_ADDR;
                    default:                state_d = ST_IDLE;
                endcase
            end
            ST_RD_ADDR: begin
                if (s_arready) state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                if (s_rvalid && s_rready) state_d = ST_IDLE;
            end
            ST_WR_ADDR: begin
                if (aw_ok && w_ok) begin
                    state_d = ST_WR_RESP;
                end else begin
                    aw_done_d = aw_ok;
                    w_done_d  = w_ok;
                end
            end
            ST_WR_RESP: begin
                if (s_bvalid && s_bready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state_q <= state_d;
            aw_done <= aw_done_d;
            w_done  <= w_done_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_lsu <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            unique case (grant)
                GNT_IFU_RD: begin
                    sel_lsu <= 1'b0;
                    addr_q  <= ifu_araddr;
                end
                GNT_LSU_RD: begin
                    sel_lsu <= 1'b1;
                    addr_q  <= lsu_araddr;
                end
                GNT_LSU_WR: begin
                    sel_lsu <= 1'b1;
                    addr_q  <= lsu_awaddr;
                    wdata_q <= lsu_wdata;
                    wstrb_q <= lsu_wstrb;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_sram_arbiter.sv
// Directed bench for axi_lite_sram_arbiter with hand-computed expectations.
module tb_axi_lite_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic [63:0] ifu_araddr, ifu_rdata;
    logic [1:0]  ifu_rresp;
    logic        lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic [63:0] lsu_araddr, lsu_rdata;
    logic [1:0]  lsu_rresp;
    logic        lsu_awvalid, lsu_awready, lsu_wvalid, lsu_wready;
    logic [63:0] lsu_awaddr, lsu_wdata;
    logic [7:0]  lsu_wstrb;
    logic        lsu_bvalid, lsu_bready;
    logic [1:0]  lsu_bresp;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [63:0] s_araddr, s_rdata;
    logic [1:0]  s_rresp;
    logic        s_awvalid, s_awready, s_wvalid, s_wready;
    logic [63:0] s_awaddr, s_wdata;
    logic [7:0]  s_wstrb;
    logic        s_bvalid, s_bready;
    logic [1:0]  s_bresp;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axi_lite_sram_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_araddr(ifu_araddr), .ifu_rvalid(ifu_rvalid),
        .ifu_rready(ifu_rready), .ifu_rdata(ifu_rdata),
        .ifu_rresp(ifu_rresp),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_araddr(lsu_araddr), .lsu_rvalid(lsu_rvalid),
        .lsu_rready(lsu_rready), .lsu_rdata(lsu_rdata),
        .lsu_rresp(lsu_rresp),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
        .lsu_awaddr(lsu_awaddr), .lsu_wvalid(lsu_wvalid),
        .lsu_wready(lsu_wready), .lsu_wdata(lsu_wdata),
        .lsu_wstrb(lsu_wstrb), .lsu_bvalid(lsu_bvalid),
        .lsu_bready(lsu_bready), .lsu_bresp(lsu_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_araddr(s_araddr), .s_rvalid(s_rvalid),
        .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_awaddr(s_awaddr), .s_wvalid(s_wvalid),
        .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the edge; checks follow 1 unit later.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = '0; ifu_rready = 1'b1;
        lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_rready = 1'b1;
        lsu_awvalid = 1'b0; lsu_awaddr = '0;
        lsu_wvalid = 1'b0; lsu_wdata = '0; lsu_wstrb = '0;
        lsu_bready = 1'b1;
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
        #2;
        chk("rst_ifu_arready", ifu_arready, 0);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_s_awaddr", s_awaddr, 0);
        chk("rst_lsu_bvalid", lsu_bvalid, 0);

        // single IFU read
        nxt();
        rst = 1'b0;
        ifu_araddr = 64'h8000_0000;
        #1;
        chk("rd_c0_ifu_arready", ifu_arready, 1);
        chk("rd_c0_lsu_arready", lsu_arready, 0);
        nxt();
        ifu_arvalid = 1'b0; s_arready = 1'b1;
        #1;
        chk("rd_c1_s_arvalid", s_arvalid, 1);
        chk("rd_c1_s_araddr", s_araddr, 64'h8000_0000);
        chk("rd_c1_ifu_arready", ifu_arready, 0);
        nxt();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h0000_0413;
        #1;
        chk("rd_c2_ifu_rvalid", ifu_rvalid, 1);
        chk("rd_c2_ifu_rdata", ifu_rdata[31:0], 32'h0000_0413);
        chk("rd_c2_lsu_rvalid", lsu_rvalid, 0);
        chk("rd_c2_s_rready", s_rready, 1);
        nxt();
        s_rvalid = 1'b0;
        #1;
        chk("rd_c3_s_arvalid", s_arvalid, 0);
        chk("rd_c3_ifu_rvalid", ifu_rvalid, 0);

        // LSU write, AW accepted at cycle 1, W at cycle 3
        lsu_awvalid = 1'b1; lsu_wvalid = 1'b1;
        lsu_awaddr = 64'h8000_1000;
        lsu_wdata = 64'hDEAD_BEEF_0000_1111;
        lsu_wstrb = 8'h0F;
        #1;
        chk("wr_c0_awready", lsu_awready, 1);
        chk("wr_c0_wready", lsu_wready, 1);
        chk("wr_c0_ifu_arready", ifu_arready, 0);
        nxt();
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0;
        s_awready = 1'b1; ifu_arvalid = 1'b1;
        #1;
        chk("wr_c1_s_awvalid", s_awvalid, 1);
        chk("wr_c1_s_wvalid", s_wvalid, 1);
        chk("wr_c1_s_awaddr", s_awaddr, 64'h8000_1000);
        chk("wr_c1_s_wdata", s_wdata, 64'hDEAD_BEEF_0000_1111);
        chk("wr_c1_s_wstrb", s_wstrb, 8'h0F);
        chk("wr_c1_holdoff", ifu_arready, 0);
        nxt();
        s_awready = 1'b0; ifu_arvalid = 1'b0;
        #1;
        chk("wr_c2_s_awvalid", s_awvalid, 0);
        chk("wr_c2_s_wvalid", s_wvalid, 1);
        nxt();
        s_wready = 1'b1;
        #1;
        chk("wr_c3_s_wvalid", s_wvalid, 1);
        chk("wr_c3_lsu_bvalid", lsu_bvalid, 0);
        nxt();
        s_wready = 1'b0; s_bvalid = 1'b1; s_bresp = 2'b00;
        #1;
        chk("wr_c4_s_wvalid", s_wvalid, 0);
        chk("wr_c4_lsu_bvalid", lsu_bvalid, 1);
        chk("wr_c4_lsu_bresp", lsu_bresp, 2'b00);
        chk("wr_c4_s_bready", s_bready, 1);
        nxt();
        s_bvalid = 1'b0;
        lsu_awvalid = 1'b1;
        #1;
        chk("aw_only_awready", lsu_awready, 0);
        chk("aw_only_wready", lsu_wready, 0);
        lsu_awvalid = 1'b0;

        // contention from reset: LSU, IFU, LSU, IFU
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        ifu_arvalid = 1'b1; ifu_araddr = 64'h100;
        lsu_arvalid = 1'b1; lsu_araddr = 64'h200;
        s_arready = 1'b1; s_rvalid = 1'b1; s_rdata = 64'h77;
        #1;
        for (int i = 0; i < 4; i++) begin
            logic exp_lsu;
            exp_lsu = (i % 2 == 0);
            chk("ct_lsu_arready", lsu_arready, exp_lsu);
            chk("ct_ifu_arready", ifu_arready, !exp_lsu);
            nxt();
            #1;
            chk("ct_s_araddr", s_araddr, exp_lsu ? 64'h200 : 64'h100);
            chk("ct_no_grant", lsu_arready | ifu_arready, 0);
            nxt();
            #1;
            chk("ct_lsu_rvalid", lsu_rvalid, exp_lsu);
            chk("ct_ifu_rvalid", ifu_rvalid, !exp_lsu);
            if (i == 3) begin
                ifu_arvalid = 1'b0;
                lsu_arvalid = 1'b0;
            end
            nxt();
            #1;
        end
        s_arready = 1'b0; s_rvalid = 1'b0;

        // backpressure on IFU read data
        ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_0004;
        #1;
        chk("bp_ifu_arready", ifu_arready, 1);
        nxt();
        ifu_arvalid = 1'b0; s_arready = 1'b1;
        nxt();
        s_arready = 1'b0; s_rvalid = 1'b1;
        s_rdata = 64'h0010_0093; ifu_rready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_s_rready", s_rready, 0);
            chk("bp_ifu_rvalid", ifu_rvalid, 1);
            chk("bp_ifu_rdata", ifu_rdata, 64'h0010_0093);
            nxt();
        end
        ifu_rready = 1'b1;
        #1;
        chk("bp_release_s_rready", s_rready, 1);
        nxt();
        s_rvalid = 1'b0;
        #1;
        chk("bp_done_ifu_rvalid", ifu_rvalid, 0);

        // SLVERR passes through on an LSU read
        lsu_arvalid = 1'b1; lsu_araddr = 64'h1000_0000;
        #1;
        chk("err_lsu_arready", lsu_arready, 1);
        nxt();
        lsu_arvalid = 1'b0; s_arready = 1'b1;
        #1;
        chk("err_s_araddr", s_araddr, 64'h1000_0000);
        nxt();
        s_arready = 1'b0; s_rvalid = 1'b1;
        s_rresp = 2'b10; s_rdata = 64'h55;
        #1;
        chk("err_lsu_rvalid", lsu_rvalid, 1);
        chk("err_lsu_rresp", lsu_rresp, 2'b10);
        chk("err_ifu_rvalid", ifu_rvalid, 0);
        nxt();
        s_rvalid = 1'b0; s_rresp = 2'b00;
        ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_0008;
        #1;
        chk("err_idle_s_arvalid", s_arvalid, 0);
        chk("err_idle_ifu_arready", ifu_arready, 1);

        // reset while the IFU read is in RD_DATA
        nxt();
        ifu_arvalid = 1'b0; s_arready = 1'b1;
        nxt();
        s_arready = 1'b0; s_rvalid = 1'b1;
        s_rdata = 64'h99; ifu_rready = 1'b0;
        #1;
        chk("mid_pending_rvalid", ifu_rvalid, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_ifu_rvalid", ifu_rvalid, 0);
        chk("mid_rst_s_rready", s_rready, 0);
        chk("mid_rst_s_arvalid", s_arvalid, 0);
        chk("mid_rst_s_araddr", s_araddr, 0);
        nxt();
        rst = 1'b0; s_rvalid = 1'b0; ifu_rready = 1'b1;
        ifu_arvalid = 1'b1; ifu_araddr = 64'h8000_000C;
        #1;
        chk("post_rst_arready", ifu_arready, 1);
        nxt();
        ifu_arvalid = 1'b0; s_arready = 1'b1;
        #1;
        chk("post_rst_s_araddr", s_araddr, 64'h8000_000C);
        nxt();
        s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 64'h0000_0013;
        #1;
        chk("post_rst_ifu_rvalid", ifu_rvalid, 1);
        chk("post_rst_ifu_rdata", ifu_rdata[31:0], 32'h0000_0013);
        nxt();
        s_rvalid = 1'b0;
        #1;
        chk("post_rst_idle", ifu_rvalid, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
